// File: rtl/multicycle_control_pkg.sv
// Shared RV32I opcode, ALU op, state and opcode-class definitions for the multicycle control FSM.
// Pure definitions: no logic, no latency.
package multicycle_control_pkg;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_BAD = 3'b011;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } state_t;

  localparam logic [2:0] CLS_NONE = 3'd0;
  localparam logic [2:0] CLS_R    = 3'd1;
  localparam logic [2:0] CLS_I    = 3'd2;
  localparam logic [2:0] CLS_LW   = 3'd3;
  localparam logic [2:0] CLS_SW   = 3'd4;
  localparam logic [2:0] CLS_BEQ  = 3'd5;

  function automatic logic [2:0] classify(input logic [6:0] opcode);
    logic [2:0] cls;
    case (opcode)
      OPC_R:   cls = CLS_R;
      OPC_I:   cls = CLS_I;
      OPC_LW:  cls = CLS_LW;
      OPC_SW:  cls = CLS_SW;
      OPC_BEQ: cls = CLS_BEQ;
      default: cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_control_alu_control_decoder.sv
// Combinational ALU-op decode from opcode class, funct3 and funct7[5]; also flags unsupported encodings.
// Zero latency, no state.
module alu_control_decoder
  import multicycle_control_pkg::*;
(
  input  logic [2:0] op_class,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output logic [3:0] alu_op,
  output logic       legal
);

  logic alt;

  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b1;
    // I-type ADDI has no SUBI form, so bit 30 only matters for shifts there
    alt    = funct7_b5 && ((op_class == CLS_R) || (funct3 == F3_SR));
    case (op_class)
      CLS_R, CLS_I: begin
        case (funct3)
          F3_ADD:  alu_op = alt ? ALU_SUB : ALU_ADD;
          F3_AND:  alu_op = ALU_AND;
          F3_OR:   alu_op = ALU_OR;
          F3_XOR:  alu_op = ALU_XOR;
          F3_SLT:  alu_op = ALU_SLT;
          F3_SLL:  alu_op = ALU_SLL;
          F3_SR:   alu_op = alt ? ALU_SRA : ALU_SRL;
          default: legal  = 1'b0;
        endcase
      end
      CLS_LW, CLS_SW: alu_op = ALU_ADD;
      CLS_BEQ:        alu_op = ALU_SUB;
      default:        legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM (IF/ID/EX/MEM/WB): latches the fetched instruction and drives ALU/datapath strobes.
// BEQ 3 cycles, ALU ops and SW 4, LW 5; IF stalls on imem_ready, MEM stalls on dmem_ready with no timeout.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             zero,
  output logic [3:0]       alu_op,
  output logic             alu_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] retired_count,
  output logic [2:0]       state_dbg
);

  state_t     state;
  logic [6:0] opcode_q;
  logic [2:0] funct3_q;
  logic       funct7_b5_q;

  logic [2:0] op_class;
  logic [3:0] dec_alu_op;
  logic       dec_legal;
  logic       unused_instr_bits;

  assign op_class          = classify(opcode_q);
  assign state_dbg         = state;
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  alu_control_decoder u_alu_dec (
    .op_class  (op_class),
    .funct3    (funct3_q),
    .funct7_b5 (funct7_b5_q),
    .alu_op    (dec_alu_op),
    .legal     (dec_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IF;
      opcode_q      <= '0;
      funct3_q      <= '0;
      funct7_b5_q   <= 1'b0;
      retired_count <= '0;
    end else begin
      case (state)
        ST_IF: begin
          if (imem_ready) begin
            opcode_q    <= instr[6:0];
            funct3_q    <= instr[14:12];
            funct7_b5_q <= instr[30];
            state       <= ST_ID;
          end
        end
        ST_ID: state <= dec_legal ? ST_EX : ST_IF;
        ST_EX: begin
          if (op_class == CLS_LW || op_class == CLS_SW) begin
            state <= ST_MEM;
          end else if (op_class == CLS_BEQ) begin
            state         <= ST_IF;
            retired_count <= retired_count + 1'b1;
          end else begin
            state <= ST_WB;
          end
        end
        ST_MEM: begin
          if (dmem_ready) begin
            if (op_class == CLS_LW) begin
              state <= ST_WB;
            end else begin
              state         <= ST_IF;
              retired_count <= retired_count + 1'b1;
            end
          end
        end
        ST_WB: begin
          state         <= ST_IF;
          retired_count <= retired_count + 1'b1;
        end
        default: state <= ST_IF;
      endcase
    end
  end

  // Strobes decode from registered state and latched fields; reset masks them immediately
  always_comb begin
    alu_op        = ALU_ADD;
    alu_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    illegal_instr = 1'b0;
    if (!rst) begin
      case (state)
        ST_IF: begin
          ir_write = imem_ready;
          pc_write = imem_ready;
        end
        ST_ID: illegal_instr = !dec_legal;
        ST_EX: begin
          alu_op  = dec_alu_op;
          alu_src = (op_class == CLS_I) || (op_class == CLS_LW) || (op_class == CLS_SW);
          if (op_class == CLS_BEQ) begin
            pc_src   = 1'b1;
            pc_write = zero;
          end
        end
        ST_MEM: begin
          mem_read  = (op_class == CLS_LW);
          mem_write = (op_class == CLS_SW);
        end
        ST_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (op_class == CLS_LW);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboarded bench: a per-instruction cycle script from the ISA rules queues expected outputs; a monitor compares each cycle.
module tb_multicycle_control;

  localparam int CW = 4;

  typedef struct packed {
    logic [2:0]    st;
    logic [3:0]    op;
    logic          src, irw, pcw, pcs, mr, mw, rw, m2r, ill;
    logic [CW-1:0] ret;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst, imem_ready, dmem_ready, zero;
  logic [31:0]   instr;
  logic [3:0]    alu_op;
  logic          alu_src, ir_write, pc_write, pc_src, mem_read, mem_write;
  logic          reg_write, mem_to_reg, illegal_instr;
  logic [CW-1:0] retired_count;
  logic [2:0]    state_dbg;

  obs_t          exp_q[$];
  logic [CW-1:0] m_ret;
  int            total = 0;
  int            bad = 0;

  multicycle_control #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .instr(instr), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .zero(zero), .alu_op(alu_op), .alu_src(alu_src),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .illegal_instr(illegal_instr),
    .retired_count(retired_count), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Monitor: one expected record per clock cycle, compared mid-cycle
  initial begin
    obs_t e, g;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = '{state_dbg, alu_op, alu_src, ir_write, pc_write, pc_src, mem_read,
              mem_write, reg_write, mem_to_reg, illegal_instr, retired_count};
        total++;
        if (g !== e) begin
          bad++;
          $display("FAIL ctrl_cycle t=%0t got st=%0d op=%b src=%b irw=%b pcw=%b pcs=%b mr=%b mw=%b rw=%b m2r=%b ill=%b ret=%0d | want st=%0d op=%b src=%b irw=%b pcw=%b pcs=%b mr=%b mw=%b rw=%b m2r=%b ill=%b ret=%0d",
                   $time, g.st, g.op, g.src, g.irw, g.pcw, g.pcs, g.mr, g.mw, g.rw, g.m2r, g.ill, g.ret,
                   e.st, e.op, e.src, e.irw, e.pcw, e.pcs, e.mr, e.mw, e.rw, e.m2r, e.ill, e.ret);
        end
      end
    end
  end

  function automatic obs_t mk(input logic [2:0] st);
    obs_t e;
    e     = '0;
    e.st  = st;
    e.op  = 4'b0010;
    e.ret = m_ret;
    return e;
  endfunction

  function automatic logic ref_legal(input logic [31:0] ins);
    case (ins[6:0])
      7'b0110011, 7'b0010011:             return ins[14:12] != 3'b011;
      7'b0000011, 7'b0100011, 7'b1100011: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // Operation named by funct3, with bit 30 choosing SUB (R only) or SRA (R and I)
  function automatic logic [3:0] ref_alu(input logic [31:0] ins);
    logic is_r;
    is_r = (ins[6:0] == 7'b0110011);
    case (ins[14:12])
      3'b000:  return (is_r && ins[30]) ? 4'b0110 : 4'b0010;
      3'b111:  return 4'b0000;
      3'b110:  return 4'b0001;
      3'b100:  return 4'b0101;
      3'b010:  return 4'b0100;
      3'b001:  return 4'b1001;
      default: return ins[30] ? 4'b1010 : 4'b1000;
    endcase
  endfunction

  task automatic step(input obs_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    zero  = 1'($urandom_range(0, 1));
    instr = $urandom;
  endtask

  // iw: imem wait cycles; dw: dmem wait cycles; zf: forced zero (-1 random); rst_mem: MEM cycle to reset in (-1 none)
  task automatic run_instr(input logic [31:0] ins, input int iw, input int dw,
                           input int zf, input int rst_mem);
    obs_t e;
    logic is_lw;
    for (int k = 0; k < iw; k++) begin
      imem_ready = 1'b0;
      step(mk(3'd0));
    end
    imem_ready = 1'b1;
    instr      = ins;
    e = mk(3'd0); e.irw = 1'b1; e.pcw = 1'b1;
    step(e);
    imem_ready = 1'b0;
    e = mk(3'd1); e.ill = !ref_legal(ins);
    step(e);
    if (!ref_legal(ins)) return;
    case (ins[6:0])
      7'b0110011, 7'b0010011: begin
        e = mk(3'd2); e.op = ref_alu(ins); e.src = (ins[6:0] == 7'b0010011);
        step(e);
        e = mk(3'd4); e.rw = 1'b1;
        step(e);
        m_ret++;
      end
      7'b1100011: begin
        if (zf >= 0) zero = zf[0];
        e = mk(3'd2); e.op = 4'b0110; e.pcs = 1'b1; e.pcw = zero;
        step(e);
        m_ret++;
      end
      default: begin
        is_lw = (ins[6:0] == 7'b0000011);
        e = mk(3'd2); e.src = 1'b1;
        step(e);
        for (int k = 0; k <= dw; k++) begin
          if (k == rst_mem) begin
            rst = 1'b1;
            dmem_ready = 1'b0;
            step(mk(3'd3));
            rst   = 1'b0;
            m_ret = '0;
            step(mk(3'd0));
            return;
          end
          dmem_ready = (k == dw);
          e = mk(3'd3); e.mr = is_lw; e.mw = !is_lw;
          step(e);
        end
        dmem_ready = 1'b0;
        if (is_lw) begin
          e = mk(3'd4); e.rw = 1'b1; e.m2r = 1'b1;
          step(e);
        end
        m_ret++;
      end
    endcase
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0, 1:    r[6:0] = 7'b0110011;
      2, 3:    r[6:0] = 7'b0010011;
      4:       r[6:0] = 7'b0000011;
      5:       r[6:0] = 7'b0100011;
      6:       r[6:0] = 7'b1100011;
      7:       begin r[6:0] = 7'b0110011; r[14:12] = 3'b011; end
      8:       ;
      default: begin r[6:0] = 7'b0010011; r[14:12] = $urandom_range(0, 1) ? 3'b011 : 3'b101; end
    endcase
    return r;
  endfunction

  initial begin
    obs_t e;
    rst = 1'b1; instr = '0; imem_ready = 1'b0; dmem_ready = 1'b0; zero = 1'b0;
    m_ret = '0;
    @(posedge clk);
    #1;
    // Still in reset with imem_ready high: strobes must stay masked
    imem_ready = 1'b1;
    step(mk(3'd0));
    rst = 1'b0;
    imem_ready = 1'b0;

    run_instr(32'h002081B3, 0, 0, -1, -1);   // ADD
    run_instr(32'h40208133, 1, 0, -1, -1);   // SUB
    run_instr(32'h4032D293, 0, 0, -1, -1);   // SRAI
    run_instr(32'h0000A183, 0, 3, -1, -1);   // LW, 3 stall cycles
    run_instr(32'h00208463, 0, 0, 1, -1);    // BEQ taken
    run_instr(32'h00208463, 0, 0, 0, -1);    // BEQ not taken
    run_instr(32'h0000007F, 5, 0, -1, -1);   // unsupported opcode after 5 idle IF cycles
    run_instr(32'h0020B033, 0, 0, -1, -1);   // R-type funct3=011
    run_instr(32'h0020A023, 0, 5, -1, 2);    // SW interrupted by reset in MEM
    run_instr(32'h002081B3, 0, 0, -1, -1);   // runs cleanly after reset

    for (int n = 0; n < 300; n++) begin
      run_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 3), -1,
                ($urandom_range(0, 24) == 0) ? $urandom_range(0, 3) : -1);
    end

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d left want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
